// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: sizing helper, default geometry and read-mode encodings.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // Read-mode encodings, shared with the asynchronous FIFO family.
  localparam int FWFT_REG  = 0;
  localparam int FWFT_FALL = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AW         = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with programmable almost flags, overflow/underflow pulses and
// selectable registered-read or first-word-fall-through output.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FWFT_REG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    r_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come only from the count register, never from this cycle's requests.
  always_comb begin
    full         = (count_q == CW'(DEPTH));
    empty        = (count_q == '0);
    almost_full  = (count_q >= CW'(AF_LEVEL));
    almost_empty = (count_q <= CW'(AE_LEVEL));
    count        = count_q;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

  always_comb begin
    wr_acc   = w_en && !full;
    rd_acc   = r_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(rd_acc);
    ovf_d    = w_en && full;
    unf_d    = r_en && empty;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Writes to the read slot only happen while empty, so no bypass is needed.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == FWFT_FALL) begin : g_fwft
      assign data_out = mem_rdata;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = rd_acc ? mem_rdata : dout_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule
